// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-stream bridge.
// Imported by the bridge top level and the receive core.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, centre-sampling FSM, and
// single-cycle byte_valid / frame_err strobes.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_serial,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 frame_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic                 sync_meta;
    logic                 sync_bit;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sample_now;

    // Preset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_meta <= UART_IDLE_LEVEL;
            sync_bit  <= UART_IDLE_LEVEL;
        end else begin
            sync_meta <= rx_serial;
            sync_bit  <= sync_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign sample_now = (cnt_q == '0);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            RX_IDLE: begin
                if (sync_bit != UART_IDLE_LEVEL) begin
                    state_d = RX_START;
                    cnt_d   = HALF_BIT;
                end
            end
            RX_START: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sync_bit != UART_IDLE_LEVEL) begin
                    state_d = RX_DATA;
                    cnt_d   = FULL_BIT;
                    idx_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {sync_bit, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_BIT;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sync_bit == UART_IDLE_LEVEL) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync_bit == UART_IDLE_LEVEL) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_q == RX_STOP && sample_now) begin
            byte_valid = (sync_bit == UART_IDLE_LEVEL);
            frame_err  = (sync_bit != UART_IDLE_LEVEL);
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/uart_stream_bridge.sv
// Byte-stream to 8N1 UART bridge: serialises the outbound valid/ready stream
// and delivers received bytes through a single-entry holding buffer.
module uart_stream_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DATA_BITS-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DATA_BITS-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 uart_tx_o,
    input  logic                 uart_rx_i,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_bit_done;

    logic                 rx_byte_valid;
    logic [DATA_BITS-1:0] rx_byte_data;
    logic                 rx_frame_err;

    assign in_ready_o  = (tx_state_q == TX_IDLE) && rstn_i;
    assign tx_bit_done = (tx_cnt_q == BIT_LAST);
    assign uart_tx_o   = tx_line_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= UART_IDLE_LEVEL;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (in_valid_i) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = in_data_i;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered output
    // lines up with the state it belongs to.
    always_comb begin
        tx_line_d = UART_IDLE_LEVEL;
        unique case (tx_state_d)
            TX_START: tx_line_d = ~UART_IDLE_LEVEL;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = UART_IDLE_LEVEL;
        endcase
    end

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .rx_serial  (uart_rx_i),
        .byte_valid (rx_byte_valid),
        .byte_data  (rx_byte_data),
        .frame_err  (rx_frame_err)
    );

    // A consumer pop on the same edge as a delivery frees the slot for it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overrun_o   <= 1'b0;
            frame_err_o <= rx_frame_err;
            if (rx_byte_valid) begin
                if (!out_valid_o || out_ready_i) begin
                    out_data_o  <= rx_byte_data;
                    out_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Self-checking bench for uart_stream_bridge at 8 clocks per bit, using a
// frame-level reference model for the serial waveform and the receive buffer.
module tb_uart_stream_bridge;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       uart_tx_o;
    logic       uart_rx_i;
    logic       frame_err_o;
    logic       overrun_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int lat = 10 * CPB;
    int ready_pulse_cyc = -1;
    bit ready_base = 1'b0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_stream_bridge #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .uart_tx_o   (uart_tx_o),
        .uart_rx_i   (uart_rx_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    // One clock: drive out_ready_i, advance, sample 1 time unit after the edge.
    task automatic step();
        out_ready_i = ready_base || (cyc + 1 == ready_pulse_cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = out_valid_o;
        if (frame_err_o === 1'b1) fe_cnt++;
        if (overrun_o === 1'b1) ov_cnt++;
    endtask

    // Offer a byte and check the whole serial frame plus in_ready_o timing.
    task automatic send_tx(input logic [7:0] data, input bit keep_valid,
                           input logic [7:0] next_data);
        logic [9:0] frame;
        logic       exp_bit;
        frame = {1'b1, data, 1'b0};
        in_valid_i = 1'b1;
        in_data_i  = data;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_before data=%02h got=%b want=1", data, in_ready_o);
        end
        step();
        if (keep_valid) begin
            in_data_i = next_data;
        end else begin
            in_valid_i = 1'b0;
            in_data_i  = 8'($urandom);
        end
        for (int k = 1; k <= 10 * CPB; k++) begin
            exp_bit = frame[(k - 1) / CPB];
            checks++;
            if (uart_tx_o !== exp_bit) begin
                errors++;
                $display("FAIL tx_line data=%02h cycle=%0d got=%b want=%b", data, k, uart_tx_o, exp_bit);
            end
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL tx_busy data=%02h cycle=%0d got=%b want=0", data, k, in_ready_o);
            end
            step();
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_after data=%02h got=%b want=1", data, in_ready_o);
        end
    endtask

    task automatic drive_rx(input logic [7:0] data, input logic stop_level,
                            output int start_cyc);
        logic [9:0] frame;
        frame = {stop_level, data, 1'b0};
        start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            uart_rx_i = frame[b];
            repeat (CPB) step();
        end
        uart_rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        uart_rx_i   = 1'b1;
        ready_base  = 1'b0;
        repeat (3) step();
        checks++;
        if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b want=1", uart_tx_o); end
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready_o); end
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid_o); end
        checks++;
        if (out_data_o !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%02h want=00", out_data_o); end
        checks++;
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b%b want=00", frame_err_o, overrun_o);
        end
        rstn_i = 1'b1;
        step();
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b want=1", in_ready_o); end
    endtask

    task automatic test_tx_frames();
        send_tx(8'hA5, 1'b0, 8'h00);
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            send_tx(8'($urandom), 1'b0, 8'h00);
            repeat ($urandom_range(0, 4)) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        send_tx(8'h00, 1'b1, 8'hFF);
        send_tx(8'hFF, 1'b0, 8'h00);
        a = 8'($urandom);
        b = 8'($urandom);
        send_tx(a, 1'b1, b);
        send_tx(b, 1'b0, 8'h00);
    endtask

    task automatic test_rx_hold();
        int st;
        int r0;
        logic [7:0] d;
        ready_base = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d  = (i == 0) ? 8'h3C : 8'($urandom);
            r0 = rise_cnt;
            drive_rx(d, 1'b1, st);
            repeat (2 * CPB) step();
            checks++;
            if (rise_cnt - r0 != 1) begin
                errors++;
                $display("FAIL rx_deliver data=%02h got=%0d want=1 rises", d, rise_cnt - r0);
            end else begin
                checks++;
                if (rise_cyc - st < 9 * CPB + 2 || rise_cyc - st > 10 * CPB + 3) begin
                    errors++;
                    $display("FAIL rx_latency data=%02h got=%0d want=%0d..%0d", d,
                             rise_cyc - st, 9 * CPB + 2, 10 * CPB + 3);
                end
                lat = rise_cyc - st;
            end
            checks++;
            if (out_data_o !== d || out_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL rx_hold got=%b/%02h want=1/%02h", out_valid_o, out_data_o, d);
            end
            ready_base = 1'b1;
            step();
            ready_base = 1'b0;
            checks++;
            if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rx_pop got=%b want=0", out_valid_o); end
        end
    endtask

    task automatic test_overrun();
        int st;
        int r0;
        int o0;
        ready_base = 1'b0;
        r0 = rise_cnt;
        o0 = ov_cnt;
        drive_rx(8'h11, 1'b1, st);
        drive_rx(8'h22, 1'b1, st);
        repeat (2 * CPB) step();
        checks++;
        if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse got=%0d want=1", ov_cnt - o0); end
        checks++;
        if (rise_cnt - r0 != 1) begin errors++; $display("FAIL ovr_rises got=%0d want=1", rise_cnt - r0); end
        checks++;
        if (out_data_o !== 8'h11 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held got=%b/%02h want=1/11", out_valid_o, out_data_o);
        end
        ready_base = 1'b1;
        step();
        ready_base = 1'b0;
        // Pop exactly on the edge that delivers the second byte.
        o0 = ov_cnt;
        drive_rx(8'h11, 1'b1, st);
        ready_pulse_cyc = cyc + lat;
        drive_rx(8'h22, 1'b1, st);
        repeat (2 * CPB) step();
        ready_pulse_cyc = -1;
        checks++;
        if (ov_cnt - o0 != 0) begin errors++; $display("FAIL same_edge_ovr got=%0d want=0", ov_cnt - o0); end
        checks++;
        if (out_data_o !== 8'h22 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_data got=%b/%02h want=1/22", out_valid_o, out_data_o);
        end
        ready_base = 1'b1;
        step();
        ready_base = 1'b0;
    endtask

    task automatic test_glitch_and_break();
        int st;
        int r0;
        int f0;
        logic [7:0] d;
        r0 = rise_cnt;
        f0 = fe_cnt;
        uart_rx_i = 1'b0;
        repeat (2) step();
        uart_rx_i = 1'b1;
        repeat (3 * CPB) step();
        checks++;
        if (rise_cnt != r0 || fe_cnt != f0) begin
            errors++;
            $display("FAIL glitch got=%0d rises %0d ferr want=0 0", rise_cnt - r0, fe_cnt - f0);
        end
        drive_rx(8'h55, 1'b0, st);
        uart_rx_i = 1'b0;
        repeat (40) step();
        uart_rx_i = 1'b1;
        repeat (2 * CPB) step();
        checks++;
        if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_ferr got=%0d want=1", fe_cnt - f0); end
        checks++;
        if (rise_cnt != r0) begin errors++; $display("FAIL break_valid got=%0d want=0", rise_cnt - r0); end
        d = 8'($urandom);
        drive_rx(d, 1'b1, st);
        repeat (2 * CPB) step();
        checks++;
        if (rise_cnt - r0 != 1 || out_data_o !== d) begin
            errors++;
            $display("FAIL after_break got=%0d/%02h want=1/%02h", rise_cnt - r0, out_data_o, d);
        end
        ready_base = 1'b1;
        step();
        ready_base = 1'b0;
    endtask

    task automatic test_reset_mid_tx();
        int st;
        logic [7:0] d;
        logic [9:0] frame;
        drive_rx(8'($urandom), 1'b1, st);
        repeat (2 * CPB) step();
        d = 8'($urandom);
        frame = {1'b1, d, 1'b0};
        in_valid_i = 1'b1;
        in_data_i  = d;
        step();
        in_valid_i = 1'b0;
        repeat (34) step();
        checks++;
        if (uart_tx_o !== frame[4]) begin
            errors++;
            $display("FAIL mid_tx_bit3 got=%b want=%b", uart_tx_o, frame[4]);
        end
        checks++;
        if (out_valid_o !== 1'b1) begin errors++; $display("FAIL pre_rst_buf got=%b want=1", out_valid_o); end
        rstn_i = 1'b0;
        step();
        checks++;
        if (uart_tx_o !== 1'b1 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got=tx%b rdy%b want=tx1 rdy0", uart_tx_o, in_ready_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_buf_lost got=%b want=0", out_valid_o); end
        rstn_i = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release got=%b want=1", in_ready_o); end
        send_tx(8'h81, 1'b0, 8'h00);
    endtask

    initial begin
        out_ready_i = 1'b0;
        test_reset();
        test_tx_frames();
        test_back_to_back();
        test_rx_hold();
        test_overrun();
        test_glitch_and_break();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
